// File: rtl/px_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : px_pkg
//  Purpose : Shared geometry, record type and FSM state encodings for the
//            pixel-array row readout path.
//  Contents: N_ROWS / N_COLS / DATA_W frame geometry, ROW_W / COL_W index
//            widths, px_t pixel code, row_rec_t buffered row record,
//            cap_state_t (capture FSM), ser_state_t (serializer FSM).
//  Revision: 1.0  initial release
// ============================================================================
package px_pkg;

  localparam int N_ROWS = 2;
  localparam int N_COLS = 2;
  localparam int DATA_W = 8;
  localparam int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int COL_W  = (N_COLS > 1) ? $clog2(N_COLS) : 1;

  typedef logic [DATA_W-1:0] px_t;

  // px[c] lines up with px_bus[c*DATA_W +: DATA_W], so the bus can be
  // stored into the record without reshuffling.
  typedef struct packed {
    logic [ROW_W-1:0]   row;
    px_t [N_COLS-1:0]   px;
  } row_rec_t;

  typedef enum logic [1:0] {
    CAP_WAIT  = 2'd0,
    CAP_COUNT = 2'd1,
    CAP_DONE  = 2'd2
  } cap_state_t;

  typedef enum logic [0:0] {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/px_row_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : px_row_fifo
//  Purpose : Small row-record FIFO with wrap-around pointers and an occupancy
//            counter. A push into a full FIFO is accepted only when a pop
//            happens in the same cycle (the pop frees the slot first);
//            otherwise the push is ignored and the contents stay unchanged.
//  Ports   : clk, rst (sync, active-low)
//            push/pushData  write side
//            pop/popData    read side, popData is the current head
//            full/empty     occupancy flags, level = entries held
//  Revision: 1.0  initial release
// ============================================================================
module px_row_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               pushData,
  input  logic                           pop,
  output logic [WIDTH-1:0]               popData,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wrPtr;
  logic [c_PTR_W-1:0] r_rdPtr;
  logic [c_LVL_W-1:0] r_level;
  logic               w_doPush;
  logic               w_doPop;

  function automatic logic [c_PTR_W-1:0] ptrInc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  assign full     = (r_level == c_LVL_W'(DEPTH));
  assign empty    = (r_level == '0);
  assign level    = r_level;
  assign popData  = r_mem[r_rdPtr];
  assign w_doPop  = pop && !empty;
  assign w_doPush = push && (!full || w_doPop);

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= ptrInc(r_wrPtr);
      if (w_doPop)  r_rdPtr <= ptrInc(r_rdPtr);
      case ({w_doPush, w_doPop})
        2'b10:   r_level <= r_level + c_LVL_W'(1);
        2'b01:   r_level <= r_level - c_LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/px_row_readout.sv
`default_nettype none
// ============================================================================
//  Module  : px_row_readout
//  Purpose : Receiving end of the pixel-array row-read bus. Samples one row of
//            pixel codes per read window, buffers whole rows and streams them
//            out one pixel per beat on a valid/ready interface.
//  Ports   : clk, rst (sync, active-low)
//            read, row_sel, px_bus                 array side
//            out_data/out_valid/out_ready,
//            out_row, out_col, out_last            consumer side
//            overflow  sticky, a sampled row was dropped (buffer full)
//            miss      sticky, a read window closed before the sample cycle
//  Revision: 1.0  initial release
// ============================================================================
module px_row_readout
  import px_pkg::*;
#(
  parameter int SAMPLE_CYC = 2,   // 1-based read-window cycle that is sampled
  parameter int ROW_DEPTH  = 2    // buffered rows
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     read,
  input  logic [ROW_W-1:0]         row_sel,
  input  logic [N_COLS*DATA_W-1:0] px_bus,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ROW_W-1:0]         out_row,
  output logic [COL_W-1:0]         out_col,
  output logic                     out_last,
  output logic                     overflow,
  output logic                     miss
);

  localparam int c_CNT_W = $clog2(SAMPLE_CYC + 1);
  localparam int c_LVL_W = $clog2(ROW_DEPTH + 1);

  // ---------------------------------------------------------------- capture
  cap_state_t         r_capState;
  logic [c_CNT_W-1:0] r_cnt;
  logic [ROW_W-1:0]   r_capRow;     // row_sel seen on the previous read cycle
  logic               r_pushReq;
  row_rec_t           r_pushRec;
  logic               r_overflow;
  logic               r_miss;

  logic               w_newWin;
  logic [c_CNT_W-1:0] w_cyc;
  logic               w_active;

  // A window opens on the first read cycle, or when row_sel moves while
  // read stays high; either way counting restarts from cycle 1.
  always_comb begin
    w_newWin = (r_capState == CAP_WAIT) || (row_sel != r_capRow);
    w_cyc    = w_newWin ? c_CNT_W'(1) : r_cnt + c_CNT_W'(1);
    w_active = read && (w_newWin || (r_capState == CAP_COUNT));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_capState <= CAP_WAIT;
      r_cnt      <= '0;
      r_capRow   <= '0;
      r_pushReq  <= 1'b0;
      r_pushRec  <= '0;
      r_miss     <= 1'b0;
    end else begin
      r_pushReq <= 1'b0;
      if (read) begin
        r_capRow <= row_sel;
        if (w_active) begin
          r_cnt <= w_cyc;
          if (w_cyc == c_CNT_W'(SAMPLE_CYC)) begin
            r_capState    <= CAP_DONE;
            r_pushReq     <= 1'b1;
            r_pushRec.row <= row_sel;
            r_pushRec.px  <= px_bus;
          end else begin
            r_capState <= CAP_COUNT;
          end
        end
      end else begin
        if (r_capState == CAP_COUNT) r_miss <= 1'b1;
        r_capState <= CAP_WAIT;
      end
    end
  end

  // ------------------------------------------------------------- row buffer
  logic [$bits(row_rec_t)-1:0] w_headRaw;
  row_rec_t                    w_head;
  logic                        w_full;
  logic                        w_empty;
  logic [c_LVL_W-1:0]          w_level;
  logic                        w_pop;

  px_row_fifo #(
    .WIDTH ($bits(row_rec_t)),
    .DEPTH (ROW_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (r_pushReq),
    .pushData (r_pushRec),
    .pop      (w_pop),
    .popData  (w_headRaw),
    .full     (w_full),
    .empty    (w_empty),
    .level    (w_level)
  );

  assign w_head = w_headRaw;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (r_pushReq && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  // ------------------------------------------------------------- serializer
  // The row being sent stays at the FIFO head until its last pixel is
  // accepted, so the payload is held steady under backpressure for free.
  ser_state_t       r_serState;
  logic [COL_W-1:0] r_col;
  logic             w_lastCol;

  assign w_lastCol = (r_col == COL_W'(N_COLS - 1));
  assign w_pop     = (r_serState == SER_SEND) && out_ready && w_lastCol;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_serState <= SER_IDLE;
      r_col      <= '0;
    end else begin
      case (r_serState)
        SER_IDLE: begin
          if (!w_empty) begin
            r_serState <= SER_SEND;
            r_col      <= '0;
          end
        end
        SER_SEND: begin
          if (out_ready) begin
            if (w_lastCol) begin
              r_col <= '0;
              // Stay in SEND when another row sits behind the one popping.
              if (w_level <= c_LVL_W'(1)) r_serState <= SER_IDLE;
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
        end
        default: r_serState <= SER_IDLE;
      endcase
    end
  end

  assign out_valid = (r_serState == SER_SEND);
  assign out_data  = out_valid ? w_head.px[r_col] : '0;
  assign out_row   = out_valid ? w_head.row : '0;
  assign out_col   = r_col;
  assign out_last  = out_valid && (w_head.row == ROW_W'(N_ROWS - 1)) && w_lastCol;
  assign overflow  = r_overflow;
  assign miss      = r_miss;

endmodule
`default_nettype wire
